// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: RV32I instruction decode stage with internal register file,
// load-use bubble insertion, flush, and a registered ID/EX output. Optional macro: RF_BYPASS_EN.
module decode_stage_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             if_valid_i,
    output logic             if_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic             flush_i,
    input  logic             wb_valid_i,
    input  logic [AW-1:0]    wb_addr_i,
    input  logic [XLEN-1:0]  wb_data_i,
    input  logic             ex_ready_i,
    output logic             id_valid_o,
    output logic [XLEN-1:0]  id_pc_o,
    output logic [XLEN-1:0]  id_rs1_data_o,
    output logic [XLEN-1:0]  id_rs2_data_o,
    output logic [XLEN-1:0]  id_imm_o,
    output logic [AW-1:0]    id_rd_o,
    output logic [AW-1:0]    id_rs1_o,
    output logic [AW-1:0]    id_rs2_o,
    output logic [2:0]       id_funct3_o,
    output logic [7:0]       id_ctrl_o,
    output logic             id_illegal_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IALU   = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_e;

    // ctrl = {RegWrite, MemRead, MemWrite, ALUSrc, MemToReg, ALUOp[2:0]}
    localparam logic [7:0] CTRL_R      = 8'b1000_0010;
    localparam logic [7:0] CTRL_IALU   = 8'b1001_0011;
    localparam logic [7:0] CTRL_LOAD   = 8'b1101_1000;
    localparam logic [7:0] CTRL_STORE  = 8'b0011_0000;
    localparam logic [7:0] CTRL_BRANCH = 8'b0000_0001;
    localparam logic [7:0] CTRL_JAL    = 8'b1000_0100;
    localparam logic [7:0] CTRL_JALR   = 8'b1001_0100;
    localparam logic [7:0] CTRL_LUI    = 8'b1001_0101;
    localparam logic [7:0] CTRL_AUIPC  = 8'b1001_0110;
    localparam int unsigned CTRL_MEMREAD = 6;

    logic [XLEN-1:0] rf [NREGS];

    logic [AW-1:0]   rs1_idx;
    logic [AW-1:0]   rs2_idx;
    logic [AW-1:0]   rd_idx;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;
    logic [7:0]      ctrl;
    logic            illegal;
    logic            rs2_used;
    logic [XLEN-1:0] rs1_rf;
    logic [XLEN-1:0] rs2_rf;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            wb_hit;
    logic            load_use;
    logic            accept;

    assign rs1_idx = instr_i[15 +: AW];
    assign rs2_idx = instr_i[20 +: AW];
    assign rd_idx  = instr_i[7 +: AW];

    always_comb begin
        imm32    = '0;
        ctrl     = '0;
        illegal  = 1'b0;
        rs2_used = 1'b0;
        case (opcode_e'(instr_i[6:0]))
            OP_R: begin
                ctrl     = CTRL_R;
                rs2_used = 1'b1;
            end
            OP_IALU: begin
                ctrl  = CTRL_IALU;
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OP_LOAD: begin
                ctrl  = CTRL_LOAD;
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OP_STORE: begin
                ctrl     = CTRL_STORE;
                rs2_used = 1'b1;
                imm32    = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OP_BRANCH: begin
                ctrl     = CTRL_BRANCH;
                rs2_used = 1'b1;
                imm32    = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                            instr_i[11:8], 1'b0};
            end
            OP_JAL: begin
                ctrl  = CTRL_JAL;
                imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
            end
            OP_JALR: begin
                ctrl  = CTRL_JALR;
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OP_LUI: begin
                ctrl  = CTRL_LUI;
                imm32 = {instr_i[31:12], 12'b0};
            end
            OP_AUIPC: begin
                ctrl  = CTRL_AUIPC;
                imm32 = {instr_i[31:12], 12'b0};
            end
            default: illegal = 1'b1;
        endcase
    end

    assign imm_ext = XLEN'($signed(imm32));

    assign wb_hit = wb_valid_i && (wb_addr_i != '0);
    assign rs1_rf = (rs1_idx == '0) ? '0 : rf[rs1_idx];
    assign rs2_rf = (rs2_idx == '0) ? '0 : rf[rs2_idx];

`ifdef RF_BYPASS_EN
    assign rs1_data = (wb_hit && (wb_addr_i == rs1_idx)) ? wb_data_i : rs1_rf;
    assign rs2_data = (wb_hit && (wb_addr_i == rs2_idx)) ? wb_data_i : rs2_rf;
`else
    assign rs1_data = rs1_rf;
    assign rs2_data = rs2_rf;
`endif

    // rs1 is compared for every format; rs2 only where the format actually reads it.
    assign load_use = id_valid_o && id_ctrl_o[CTRL_MEMREAD] && (id_rd_o != '0) && if_valid_i &&
                      ((id_rd_o == rs1_idx) || (rs2_used && (id_rd_o == rs2_idx)));

    assign if_ready_o = (!id_valid_o || ex_ready_i) && !load_use && !flush_i;
    assign accept     = if_valid_i && if_ready_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_hit) begin
            rf[wb_addr_i] <= wb_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            id_valid_o    <= 1'b0;
            id_pc_o       <= '0;
            id_rs1_data_o <= '0;
            id_rs2_data_o <= '0;
            id_imm_o      <= '0;
            id_rd_o       <= '0;
            id_rs1_o      <= '0;
            id_rs2_o      <= '0;
            id_funct3_o   <= '0;
            id_ctrl_o     <= '0;
            id_illegal_o  <= 1'b0;
            stall_cnt_o   <= '0;
        end else begin
            if (flush_i) begin
                id_valid_o <= 1'b0;
            end else if (accept) begin
                id_valid_o    <= 1'b1;
                id_pc_o       <= pc_i;
                id_rs1_data_o <= rs1_data;
                id_rs2_data_o <= rs2_data;
                id_imm_o      <= imm_ext;
                id_rd_o       <= rd_idx;
                id_rs1_o      <= rs1_idx;
                id_rs2_o      <= rs2_idx;
                id_funct3_o   <= instr_i[14:12];
                id_ctrl_o     <= ctrl;
                id_illegal_o  <= illegal;
            end else if (!id_valid_o || ex_ready_i) begin
                id_valid_o <= 1'b0;
            end else begin
`ifdef RF_BYPASS_EN
                // Stalled entry keeps its operands current with the register file.
                if (wb_hit && (wb_addr_i == id_rs1_o)) begin
                    id_rs1_data_o <= wb_data_i;
                end
                if (wb_hit && (wb_addr_i == id_rs2_o)) begin
                    id_rs2_data_o <= wb_data_i;
                end
`endif
            end

            if (load_use && ex_ready_i && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed checks of decode, handshake, load-use bubble, flush and register file.
// Expected operand values after same-cycle write-back depend on RF_BYPASS_EN.
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [2:0]  id_funct3;
    logic [7:0]  id_ctrl;
    logic        id_illegal;
    logic [15:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    decode_stage_pipe #(.XLEN(32), .NREGS(32), .CNT_W(16)) dut (
        .clk_i(clk), .reset_i(reset), .if_valid_i(if_valid), .if_ready_o(if_ready),
        .instr_i(instr), .pc_i(pc), .flush_i(flush), .wb_valid_i(wb_valid),
        .wb_addr_i(wb_addr), .wb_data_i(wb_data), .ex_ready_i(ex_ready),
        .id_valid_o(id_valid), .id_pc_o(id_pc), .id_rs1_data_o(id_rs1_data),
        .id_rs2_data_o(id_rs2_data), .id_imm_o(id_imm), .id_rd_o(id_rd),
        .id_rs1_o(id_rs1), .id_rs2_o(id_rs2), .id_funct3_o(id_funct3),
        .id_ctrl_o(id_ctrl), .id_illegal_o(id_illegal), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] addr);
        if_valid = 1'b1;
        instr    = ins;
        pc       = addr;
    endtask

    task automatic test_reset;
        reset = 1'b1; if_valid = 1'b0; instr = '0; pc = '0; flush = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b0;
        tick; tick;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", id_valid); end
        checks++; if (stall_cnt !== 16'h0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", stall_cnt); end
        checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", id_pc); end
        checks++; if (id_ctrl !== 8'h0) begin failures++; $display("FAIL reset_ctrl got=%0h exp=0", id_ctrl); end
        reset = 1'b0; ex_ready = 1'b1;
        #1;
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL reset_if_ready got=%0h exp=1", if_ready); end
    endtask

    task automatic test_addi;
        drive(32'hFFB00093, 32'h100);
        #1;
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL addi_if_ready got=%0h exp=1", if_ready); end
        tick;
        if_valid = 1'b0;
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0h exp=1", id_valid); end
        checks++; if (id_imm !== 32'hFFFFFFFB) begin failures++; $display("FAIL addi_imm got=%0h exp=fffffffb", id_imm); end
        checks++; if (id_rd !== 5'd1) begin failures++; $display("FAIL addi_rd got=%0h exp=1", id_rd); end
        checks++; if (id_pc !== 32'h100) begin failures++; $display("FAIL addi_pc got=%0h exp=100", id_pc); end
        checks++; if (id_ctrl !== 8'h93) begin failures++; $display("FAIL addi_ctrl got=%0h exp=93", id_ctrl); end
        checks++; if (id_illegal !== 1'b0) begin failures++; $display("FAIL addi_illegal got=%0h exp=0", id_illegal); end
        tick;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL addi_drain got=%0h exp=0", id_valid); end
    endtask

    task automatic test_regfile;
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h40; tick;
        wb_addr = 5'd7; wb_data = 32'h1111; tick;
        wb_addr = 5'd5; wb_data = 32'h55; tick;
        // write to x0 while reading x0 through add x10,x0,x0
        wb_addr = 5'd0; wb_data = 32'hDEAD;
        drive(32'h00000533, 32'h180);
        tick;
        wb_valid = 1'b0; if_valid = 1'b0;
        checks++; if (id_rs1_data !== 32'h0) begin failures++; $display("FAIL x0_same_cycle got=%0h exp=0", id_rs1_data); end
        tick;
        drive(32'h00000533, 32'h184);
        tick;
        if_valid = 1'b0;
        checks++; if (id_rs2_data !== 32'h0) begin failures++; $display("FAIL x0_after_write got=%0h exp=0", id_rs2_data); end
        drive(32'h004284B3, 32'h188);
        tick;
        if_valid = 1'b0;
        checks++; if (id_rs1_data !== 32'h55) begin failures++; $display("FAIL rf_x5 got=%0h exp=55", id_rs1_data); end
        checks++; if (id_rs2_data !== 32'h40) begin failures++; $display("FAIL rf_x4 got=%0h exp=40", id_rs2_data); end
        tick;
    endtask

    task automatic test_load_use;
        drive(32'h0000A103, 32'h200);
        tick;
        checks++; if (id_ctrl !== 8'hD8) begin failures++; $display("FAIL lw_ctrl got=%0h exp=d8", id_ctrl); end
        drive(32'h004101B3, 32'h204);
        #1;
        checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL lu_if_ready got=%0h exp=0", if_ready); end
        tick;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%0h exp=0", id_valid); end
        checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0h exp=1", stall_cnt); end
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL lu_release got=%0h exp=1", if_ready); end
        tick;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h204) begin failures++; $display("FAIL lu_issue got=%0h/%0h exp=1/204", id_valid, id_pc); end
        checks++; if (id_rs2_data !== 32'h40) begin failures++; $display("FAIL lu_rs2_data got=%0h exp=40", id_rs2_data); end
        checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_single_bubble got=%0h exp=1", stall_cnt); end
        // I-type whose imm field aliases the load's rd must not stall
        drive(32'h0000A103, 32'h208);
        tick;
        drive(32'h00208313, 32'h20C);
        #1;
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL itype_no_hazard got=%0h exp=1", if_ready); end
        tick;
        if_valid = 1'b0;
        checks++; if (id_pc !== 32'h20C || stall_cnt !== 16'd1) begin failures++; $display("FAIL itype_issue got=%0h/%0h exp=20c/1", id_pc, stall_cnt); end
        tick;
    endtask

    task automatic test_hold_flush;
        drive(32'h0030A423, 32'h300);
        tick;
        ex_ready = 1'b0;
        drive(32'hABCDE2B7, 32'h304);
        #1;
        checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL hold_if_ready got=%0h exp=0", if_ready); end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'h300 || id_imm !== 32'h8 || id_ctrl !== 8'h30 || if_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d got=%0h/%0h/%0h/%0h/%0h exp=1/300/8/30/0", i, id_valid, id_pc, id_imm, id_ctrl, if_ready);
            end
        end
        flush = 1'b1;
        tick;
        flush = 1'b0;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_stalled got=%0h exp=0", id_valid); end
        ex_ready = 1'b1;
        tick;
        checks++; if (id_valid !== 1'b1 || id_imm !== 32'hABCDE000) begin failures++; $display("FAIL lui_issue got=%0h/%0h exp=1/abcde000", id_valid, id_imm); end
        checks++; if (id_ctrl !== 8'h95 || id_rd !== 5'd5) begin failures++; $display("FAIL lui_ctrl_rd got=%0h/%0h exp=95/5", id_ctrl, id_rd); end
        drive(32'hFE000EE3, 32'h308);
        flush = 1'b1;
        #1;
        checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL flush_if_ready got=%0h exp=0", if_ready); end
        tick;
        flush = 1'b0;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0h exp=0", id_valid); end
        tick;
        if_valid = 1'b0;
        checks++; if (id_pc !== 32'h308 || id_imm !== 32'hFFFFFFFC) begin failures++; $display("FAIL beq_imm got=%0h/%0h exp=308/fffffffc", id_pc, id_imm); end
        checks++; if (id_ctrl !== 8'h01) begin failures++; $display("FAIL beq_ctrl got=%0h exp=1", id_ctrl); end
        tick;
    endtask

    task automatic test_bypass;
        logic [31:0] exp_rs1;
`ifdef RF_BYPASS_EN
        exp_rs1 = 32'h1234;
`else
        exp_rs1 = 32'h1111;
`endif
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
        drive(32'h00038433, 32'h400);
        tick;
        wb_valid = 1'b0; if_valid = 1'b0;
        checks++; if (id_rs1_data !== exp_rs1) begin failures++; $display("FAIL same_cycle_wb got=%0h exp=%0h", id_rs1_data, exp_rs1); end
        tick;
        drive(32'h00038433, 32'h404);
        tick;
        if_valid = 1'b0;
        checks++; if (id_rs1_data !== 32'h1234) begin failures++; $display("FAIL wb_landed got=%0h exp=1234", id_rs1_data); end
        tick;
    endtask

    task automatic test_illegal;
        drive(32'h0000007F, 32'h500);
        tick;
        if_valid = 1'b0;
        checks++; if (id_illegal !== 1'b1 || id_valid !== 1'b1) begin failures++; $display("FAIL illegal_flag got=%0h/%0h exp=1/1", id_illegal, id_valid); end
        checks++; if (id_ctrl !== 8'h0) begin failures++; $display("FAIL illegal_ctrl got=%0h exp=0", id_ctrl); end
        drive(32'hFFB00093, 32'h504);
        tick;
        if_valid = 1'b0;
        checks++; if (id_illegal !== 1'b0) begin failures++; $display("FAIL illegal_clear got=%0h exp=0", id_illegal); end
    endtask

    task automatic test_reset_mid;
        drive(32'h004284B3, 32'h600);
        tick;
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%0h exp=1", id_valid); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++; if (id_valid !== 1'b0 || stall_cnt !== 16'h0 || id_pc !== 32'h0) begin failures++; $display("FAIL mid_reset got=%0h/%0h/%0h exp=0/0/0", id_valid, stall_cnt, id_pc); end
        tick;
        if_valid = 1'b0;
        checks++; if (id_valid !== 1'b1 || id_rs1_data !== 32'h0 || id_rs2_data !== 32'h0) begin failures++; $display("FAIL mid_rf_cleared got=%0h/%0h/%0h exp=1/0/0", id_valid, id_rs1_data, id_rs2_data); end
        tick;
    endtask

    initial begin
        test_reset;
        test_addi;
        test_regfile;
        test_load_use;
        test_hold_flush;
        test_bypass;
        test_illegal;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
